// File: rtl/mac_link_watchdog_if.sv
// Bundle between the MAC bring-up supervisor (master side: enable, bring-up
// status, block lock, clear_fail) and mac_link_watchdog (slave side: restart
// request, link status, retry and statistics counters).
//   enable             master -> slave   hold watchdog in idle when low
//   completion_status  master -> slave   bring-up FSM completion code
//   stat_rx_block_lock master -> slave   block lock, synchronised to dclk
//   clear_fail         master -> slave   pulse: leave the failed state
//   fsm_restart        slave -> master   restart request to bring-up FSM
//   link_up            slave -> master   link established and stable
//   link_failed        slave -> master   retries exhausted (sticky)
//   retry_cnt          slave -> master   consecutive restarts since last link-up
//   link_down_cnt      slave -> master   link-loss events (stats build only)
//   last_fail_code     slave -> master   code of the last failure (stats build only)
interface mac_link_watchdog_if #(
   parameter int unsigned RW = 4
);
   logic          enable;
   logic [4:0]    completion_status;
   logic          stat_rx_block_lock;
   logic          clear_fail;
   logic          fsm_restart;
   logic          link_up;
   logic          link_failed;
   logic [RW-1:0] retry_cnt;
   logic [15:0]   link_down_cnt;
   logic [4:0]    last_fail_code;

   modport master (
      output enable, completion_status, stat_rx_block_lock, clear_fail,
      input  fsm_restart, link_up, link_failed, retry_cnt, link_down_cnt, last_fail_code
   );

   modport slave (
      input  enable, completion_status, stat_rx_block_lock, clear_fail,
      output fsm_restart, link_up, link_failed, retry_cnt, link_down_cnt, last_fail_code
   );
endinterface

// File: rtl/mac_link_watchdog.sv
// Watchdog around the 10G/25G MAC bring-up FSM: retries failed or timed-out
// bring-ups, re-runs bring-up on debounced loss of block lock, and gives up
// (sticky link_failed) after MAX_RETRIES consecutive restarts.
// Ports:
//   dclk        control clock, shared with the bring-up FSM
//   sys_resetn  asynchronous active-low reset
//   wd          mac_link_watchdog_if.slave (status inputs, restart/link outputs)
// Optional feature: define WD_STATS_EN to build link_down_cnt and
// last_fail_code; otherwise both read as zero and no registers exist for them.
module mac_link_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES  = 200000,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned RESTART_CYCLES  = 4,
   parameter int unsigned BACKOFF_CYCLES  = 1000,
   parameter int unsigned MAX_RETRIES     = 3,
   parameter int unsigned RW              = 4
) (
   input logic                dclk,
   input logic                sys_resetn,
   mac_link_watchdog_if.slave wd
);

   // One shared down-counter must hold the largest load value.
   localparam int unsigned T_MAX_A = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
   localparam int unsigned T_MAX_B = (DEBOUNCE_CYCLES > RESTART_CYCLES) ? DEBOUNCE_CYCLES : RESTART_CYCLES;
   localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int unsigned TW      = $clog2(T_MAX + 1);

   localparam logic [4:0] CODE_TEST_START = 5'd0;
   localparam logic [4:0] CODE_SUCCESS    = 5'd1;
   localparam logic [4:0] CODE_NO_START   = 5'd31;

   typedef enum logic [2:0] {
      WD_IDLE    = 3'd0,
      WD_WAIT    = 3'd1,
      WD_UP      = 3'd2,
      WD_RESTART = 3'd3,
      WD_BACKOFF = 3'd4,
      WD_FAILED  = 3'd5
   } wd_state_e;

   wd_state_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          restart_q, restart_d;
   logic          link_up_q, link_up_d;
   logic          failed_q, failed_d;

   logic          is_fail_c;
   logic          fail_go_c;
   logic          up_loss_c;
   logic [TW-1:0] tmr_dec_c;

   assign is_fail_c = (wd.completion_status != CODE_TEST_START) &&
                      (wd.completion_status != CODE_SUCCESS) &&
                      (wd.completion_status != CODE_NO_START);
   assign tmr_dec_c = (timer_q != '0) ? (timer_q - TW'(1)) : '0;

   // Next-state and next-output logic; fail_go_c funnels every cause into the FAIL path.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      restart_d = restart_q;
      link_up_d = link_up_q;
      failed_d  = failed_q;
      fail_go_c = 1'b0;
      up_loss_c = 1'b0;

      if (!wd.enable) begin
         state_d   = WD_IDLE;
         timer_d   = '0;
         restart_d = 1'b0;
         link_up_d = 1'b0;
      end else begin
         case (state_q)
            WD_IDLE: begin
               state_d = WD_WAIT;
               timer_d = TW'(TIMEOUT_CYCLES);
            end
            WD_WAIT: begin
               // Success beats timeout on the last cycle; failure beats both.
               if (is_fail_c) begin
                  fail_go_c = 1'b1;
               end else if ((wd.completion_status == CODE_SUCCESS) && wd.stat_rx_block_lock) begin
                  state_d   = WD_UP;
                  link_up_d = 1'b1;
                  retry_d   = '0;
                  timer_d   = TW'(DEBOUNCE_CYCLES);
               end else if (timer_q <= TW'(1)) begin
                  fail_go_c = 1'b1;
               end else begin
                  timer_d = tmr_dec_c;
               end
            end
            WD_UP: begin
               // Timer is the lock-low debounce counter here.
               if (is_fail_c) begin
                  fail_go_c = 1'b1;
                  up_loss_c = 1'b1;
               end else if (!wd.stat_rx_block_lock) begin
                  if (timer_q <= TW'(1)) begin
                     fail_go_c = 1'b1;
                     up_loss_c = 1'b1;
                  end else begin
                     timer_d = tmr_dec_c;
                  end
               end else begin
                  timer_d = TW'(DEBOUNCE_CYCLES);
               end
            end
            WD_RESTART: begin
               if (timer_q <= TW'(1)) begin
                  state_d   = WD_BACKOFF;
                  restart_d = 1'b0;
                  timer_d   = TW'(BACKOFF_CYCLES);
               end else begin
                  timer_d = tmr_dec_c;
               end
            end
            WD_BACKOFF: begin
               // Status deliberately ignored while the FSM passes through 31/0.
               if (timer_q <= TW'(1)) begin
                  state_d = WD_WAIT;
                  timer_d = TW'(TIMEOUT_CYCLES);
               end else begin
                  timer_d = tmr_dec_c;
               end
            end
            WD_FAILED: begin
               if (wd.clear_fail) begin
                  state_d   = WD_RESTART;
                  retry_d   = '0;
                  failed_d  = 1'b0;
                  restart_d = 1'b1;
                  timer_d   = TW'(RESTART_CYCLES);
               end
            end
            default: begin
               state_d = WD_IDLE;
               timer_d = '0;
            end
         endcase

         if (up_loss_c) begin
            link_up_d = 1'b0;
         end

         if (fail_go_c) begin
            if (retry_q >= RW'(MAX_RETRIES)) begin
               state_d  = WD_FAILED;
               failed_d = 1'b1;
               timer_d  = '0;
            end else begin
               state_d   = WD_RESTART;
               retry_d   = retry_q + RW'(1);
               restart_d = 1'b1;
               timer_d   = TW'(RESTART_CYCLES);
            end
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge dclk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state_q   <= WD_IDLE;
         timer_q   <= '0;
         retry_q   <= '0;
         restart_q <= 1'b0;
         link_up_q <= 1'b0;
         failed_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         retry_q   <= retry_d;
         restart_q <= restart_d;
         link_up_q <= link_up_d;
         failed_q  <= failed_d;
      end
   end

   assign wd.fsm_restart = restart_q;
   assign wd.link_up     = link_up_q;
   assign wd.link_failed = failed_q;
   assign wd.retry_cnt   = retry_q;

`ifdef WD_STATS_EN
   logic [15:0] down_cnt_q, down_cnt_d;
   logic [4:0]  code_q, code_d;

   // Link-loss count saturates; non-status causes (timeout, lock loss) record 31.
   always_comb begin
      down_cnt_d = down_cnt_q;
      code_d     = code_q;
      if (up_loss_c && (down_cnt_q != 16'hFFFF)) begin
         down_cnt_d = down_cnt_q + 16'd1;
      end
      if (fail_go_c) begin
         code_d = is_fail_c ? wd.completion_status : CODE_NO_START;
      end
   end

   always_ff @(posedge dclk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         down_cnt_q <= '0;
         code_q     <= '0;
      end else begin
         down_cnt_q <= down_cnt_d;
         code_q     <= code_d;
      end
   end

   assign wd.link_down_cnt  = down_cnt_q;
   assign wd.last_fail_code = code_q;
`else
   assign wd.link_down_cnt  = '0;
   assign wd.last_fail_code = '0;
`endif

endmodule
